// File: rtl/load_updown_counter_pkg.sv
// Shared constants for the load/up-down counter: direction encoding on
// up_down_bar and the range-end behaviour selected by SATURATE.
package load_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 32'sd0;
    localparam int MODE_SAT  = 32'sd1;

endpackage : load_updown_counter_pkg

// File: rtl/load_updown_counter_sticky_flag.sv
// Sticky event flag: set on an event, held until cleared; a set on the same
// edge as a clear wins so an event is never lost.
module sticky_flag (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);

    logic q_r;

    // Flag register with set-over-clear priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= 1'b0;
        end else if (set) begin
            q_r <= 1'b1;
        end else if (clr) begin
            q_r <= 1'b0;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : sticky_flag

// File: rtl/load_updown_counter.sv
// Modulo-MOD up/down counter with clamped parallel load, wrap or saturate at
// the range ends, a combinational terminal-count output and sticky ovf/unf.
module load_updown_counter
    import load_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_down_bar,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    generate
        if ((MOD < 2) || (MOD > (2 ** WIDTH))) begin : g_bad_mod
            $error("load_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
        end
        if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
            $error("load_updown_counter: SATURATE must be MODE_WRAP or MODE_SAT");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             ovf_set_s;
    logic             unf_set_s;
    logic             tc_s;

    assign at_max_s  = (count_r == MAX_C);
    assign at_zero_s = (count_r == ZERO_C);

    // Next count: load beats counting; range ends wrap or hold and raise an event.
    always_comb begin
        next_count_s = count_r;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        if (load) begin
            if (load_val > MAX_C) begin
                next_count_s = MAX_C;
            end else begin
                next_count_s = load_val;
            end
        end else if (en) begin
            if (up_down_bar == DIR_UP) begin
                if (at_max_s) begin
                    ovf_set_s    = 1'b1;
                    next_count_s = (SATURATE == MODE_SAT) ? MAX_C : ZERO_C;
                end else begin
                    next_count_s = count_r + ONE_C;
                end
            end else begin
                if (at_zero_s) begin
                    unf_set_s    = 1'b1;
                    next_count_s = (SATURATE == MODE_SAT) ? ZERO_C : MAX_C;
                end else begin
                    next_count_s = count_r - ONE_C;
                end
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // Terminal count flags the edge on which an end-of-range event will occur.
    always_comb begin
        tc_s = 1'b0;
        if (en && !load) begin
            if (up_down_bar == DIR_UP) begin
                tc_s = at_max_s;
            end else begin
                tc_s = at_zero_s;
            end
        end else begin
            tc_s = 1'b0;
        end
    end

    // Count register; reset clears it without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_C;
        end else begin
            count_r <= next_count_s;
        end
    end

    sticky_flag u_ovf_flag (
        .clk (clk),
        .rst (rst),
        .set (ovf_set_s),
        .clr (clr_flags),
        .q   (ovf)
    );

    sticky_flag u_unf_flag (
        .clk (clk),
        .rst (rst),
        .set (unf_set_s),
        .clr (clr_flags),
        .q   (unf)
    );

    assign count = count_r;
    assign tc    = tc_s;

endmodule : load_updown_counter

// File: tb/tb_load_updown_counter.sv
// Directed bench: default counter (A) plus saturating (B) and wrapping (C)
// instances with MOD=10, the latter two sharing one stimulus set.
module tb_load_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_en = 1'b0, a_load = 1'b0, a_ud = 1'b1, a_clr = 1'b0;
    logic [3:0] a_lv = 4'd0;
    logic [3:0] a_count;
    logic       a_tc, a_ovf, a_unf;

    logic       b_en = 1'b0, b_load = 1'b0, b_ud = 1'b1, b_clr = 1'b0;
    logic [3:0] b_lv = 4'd0;
    logic [3:0] b_count, c_count;
    logic       b_tc, b_ovf, b_unf, c_tc, c_ovf, c_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_updown_counter u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .load(a_load), .load_val(a_lv),
        .up_down_bar(a_ud), .clr_flags(a_clr),
        .count(a_count), .tc(a_tc), .ovf(a_ovf), .unf(a_unf)
    );

    load_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .load(b_load), .load_val(b_lv),
        .up_down_bar(b_ud), .clr_flags(b_clr),
        .count(b_count), .tc(b_tc), .ovf(b_ovf), .unf(b_unf)
    );

    load_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) u_dut_c (
        .clk(clk), .rst(rst), .en(b_en), .load(b_load), .load_val(b_lv),
        .up_down_bar(b_ud), .clr_flags(b_clr),
        .count(c_count), .tc(c_tc), .ovf(c_ovf), .unf(c_unf)
    );

    typedef struct {
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       ud;
        logic       clr;
        logic       tc;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply_a(input logic ld, input logic [3:0] lv, input logic e,
                           input logic ud, input logic c);
        @(negedge clk);
        a_load = ld; a_lv = lv; a_en = e; a_ud = ud; a_clr = c;
        #1;
    endtask

    task automatic apply_b(input logic ld, input logic [3:0] lv, input logic e,
                           input logic ud, input logic c);
        @(negedge clk);
        b_load = ld; b_lv = lv; b_en = e; b_ud = ud; b_clr = c;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_updown[9];
        int exp_b[4];
        int exp_c[4];

        vt[0]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        vt[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1};
        vt[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 4'd7,  1'b0, 1'b1};
        vt[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd6,  1'b0, 1'b1};
        vt[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  1'b0, 1'b1};
        vt[8]  = '{1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 4'd13, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd13, 1'b0, 1'b0};
        vt[10] = '{1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0};
        vt[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0};
        vt[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
        exp_updown = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
        exp_b      = '{8, 9, 9, 9};
        exp_c      = '{8, 9, 0, 1};

        // Reset state, and tc evaluated against count=0 while in reset.
        a_en = 1'b1; a_ud = 1'b0;
        #12;
        chk("rst_count", a_count, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);
        chk("rst_tc_down", a_tc, 1);

        // Count up through a full wrap.
        @(negedge clk);
        rst = 1'b0; a_en = 1'b1; a_ud = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_count", k), a_count, k % 16);
            chk($sformatf("wrap%0d_tc", k), a_tc, (k == 15) ? 1 : 0);
            chk($sformatf("wrap%0d_ovf", k), a_ovf, (k == 16) ? 1 : 0);
            if (k == 16) a_en = 1'b0;
        end

        for (int i = 0; i < 13; i++) begin
            apply_a(vt[i].load, vt[i].lv, vt[i].en, vt[i].ud, vt[i].clr);
            chk($sformatf("v%0d_tc", i), a_tc, vt[i].tc);
            edge_wait();
            chk($sformatf("v%0d_count", i), a_count, vt[i].cnt);
            chk($sformatf("v%0d_ovf", i), a_ovf, vt[i].ovf);
            chk($sformatf("v%0d_unf", i), a_unf, vt[i].unf);
        end

        // Asynchronous reset between edges while count=7 with ovf set.
        apply_a(1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
        edge_wait();
        apply_a(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        edge_wait();
        apply_a(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
        edge_wait();
        chk("pre_arst_count", a_count, 7);
        chk("pre_arst_ovf", a_ovf, 1);
        a_load = 1'b0; a_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", a_count, 0);
        chk("arst_ovf", a_ovf, 0);
        chk("arst_unf", a_unf, 0);
        @(negedge clk);
        rst = 1'b0;
        edge_wait();
        chk("resume1_count", a_count, 1);
        edge_wait();
        chk("resume2_count", a_count, 2);

        // Direction toggled every three cycles.
        apply_a(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        edge_wait();
        for (int i = 0; i < 9; i++) begin
            apply_a(1'b0, 4'd0, 1'b1, ((i / 3) % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            edge_wait();
            chk($sformatf("updown%0d_count", i), a_count, exp_updown[i]);
        end
        a_en = 1'b0;

        // Range of ten: clamped load wins over en and sets no flag.
        apply_b(1'b1, 4'd13, 1'b1, 1'b1, 1'b0);
        chk("b_load_tc", b_tc, 0);
        edge_wait();
        chk("b_clamp_count", b_count, 9);
        chk("c_clamp_count", c_count, 9);
        chk("b_clamp_ovf", b_ovf, 0);
        chk("b_clamp_unf", b_unf, 0);
        chk("c_clamp_ovf", c_ovf, 0);

        // Load 8 then count up: saturate holds at 9, wrap goes modulo 10.
        apply_b(1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
        edge_wait();
        for (int i = 0; i < 4; i++) begin
            apply_b(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("b_up%0d_count", i), b_count, exp_b[i]);
            chk($sformatf("b_up%0d_tc", i), b_tc, (i > 0) ? 1 : 0);
            chk($sformatf("c_up%0d_count", i), c_count, exp_c[i]);
            chk($sformatf("c_up%0d_tc", i), c_tc, (i == 1) ? 1 : 0);
            edge_wait();
        end
        chk("b_sat_count", b_count, 9);
        chk("b_sat_ovf", b_ovf, 1);
        chk("b_sat_unf", b_unf, 0);
        chk("c_wrap_count", c_count, 2);
        chk("c_wrap_ovf", c_ovf, 1);

        // Down at zero: saturate holds at 0, wrap goes to MOD-1.
        apply_b(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        edge_wait();
        chk("b_clr_ovf", b_ovf, 0);
        apply_b(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("b_down_tc", b_tc, 1);
        chk("c_down_tc", c_tc, 1);
        edge_wait();
        chk("b_down_count", b_count, 0);
        chk("b_down_unf", b_unf, 1);
        chk("c_down_count", c_count, 9);
        chk("c_down_unf", c_unf, 1);
        b_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_load_updown_counter

// File: doc/load_updown_counter.md
LOAD_UPDOWN_COUNTER -- requirements
Module: load_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits.
REQ-002 Parameter MOD, default 16: count range is 0..MOD-1; legal range is 2 <= MOD <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends; 1 = hold at range ends.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port en, input, 1 bit: count enable.
REQ-007 Port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 Port load_val, input, WIDTH bits: value to load.
REQ-009 Port up_down_bar, input, 1 bit: direction; 1 = up, 0 = down.
REQ-010 Port clr_flags, input, 1 bit: synchronous clear for the sticky flags.
REQ-011 Port count, output, WIDTH bits: current count, registered.
REQ-012 Port tc, output, 1 bit: terminal-count indication, combinational.
REQ-013 Port ovf, output, 1 bit: sticky overflow flag, registered.
REQ-014 Port unf, output, 1 bit: sticky underflow flag, registered.

Function
REQ-015 Per-edge priority SHALL be: rst, then load, then en-count, then hold.
REQ-016 When load=1, count SHALL take load_val on the next edge regardless of en or up_down_bar.
REQ-017 A load_val >= MOD SHALL be clamped to MOD-1; a load SHALL never set ovf or unf.
REQ-018 When load=0, en=1, up_down_bar=1 and count < MOD-1, count SHALL increment by 1 on the next edge.
REQ-019 When load=0, en=1, up_down_bar=0 and count > 0, count SHALL decrement by 1 on the next edge.
REQ-020 Up at count=MOD-1: next count SHALL be 0 if SATURATE=0, or MOD-1 if SATURATE=1; ovf SHALL be set in both modes.
REQ-021 Down at count=0: next count SHALL be MOD-1 if SATURATE=0, or 0 if SATURATE=1; unf SHALL be set in both modes.
REQ-022 en=0 with load=0 SHALL hold count and both flags, except as cleared by clr_flags.
REQ-023 tc SHALL be 1 exactly when en=1, load=0, and either (up_down_bar=1 and count=MOD-1) or (up_down_bar=0 and count=0).
REQ-024 tc SHALL have zero latency; count, ovf and unf SHALL have one-cycle latency.
REQ-025 ovf and unf SHALL remain 1 until clr_flags=1 or rst.
REQ-026 If clr_flags=1 and a new overflow or underflow occurs on the same edge, the affected flag SHALL be 1 after that edge (set wins).
REQ-027 A direction change SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-028 All arithmetic SHALL be modulo MOD, never modulo 2**WIDTH, unless MOD=2**WIDTH.

Reset
REQ-029 rst=1 SHALL force count=0, ovf=0 and unf=0 immediately, independent of clk.
REQ-030 During rst, tc SHALL follow REQ-023 using count=0.
REQ-031 Deasserting rst in the middle of a sequence SHALL resume counting from 0 on the first edge after deassertion, with no loss of further edges.

Structure
REQ-032 A shared package SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the SATURATE mode constants (MODE_WRAP=0, MODE_SAT=1).
REQ-033 The sticky flag logic SHALL be one sub-module, sticky_flag (ports: clk, rst, set, clr, q; set wins over clr), instantiated for ovf and for unf.
REQ-034 Illegal MOD values SHALL be rejected at elaboration.

Verification
REQ-035 Defaults, rst pulse, then en=1, up_down_bar=1 for 17 cycles -> count steps 0..15 then 0; tc=1 during the count=15 cycle; ovf=1 from the wrap onward.
REQ-036 MOD=10, SATURATE=1, load load_val=8, then up for 4 cycles -> count sequence 8, 9, 9, 9; ovf=1; unf=0.
REQ-037 MOD=10, load_val=13 -> count=9 on the next edge; no flag set; loaded on the same edge as en=1 -> load wins.
REQ-038 Defaults at count=0, en=1, up_down_bar=0 -> count=15 and unf=1; clr_flags=1 on the same edge as a further underflow -> unf stays 1.
REQ-039 rst asserted between clock edges while count=7 -> count=0, ovf=0, unf=0 with no clock edge; after release, counting resumes from 0 on the next edge.
REQ-040 Toggle up_down_bar every 3 cycles with en=1 -> count follows 1, 2, 3, 2, 1, 0, 1, ... with no skipped or stalled edge.
